// File: rtl/cpu_axi_bridge_pkg.sv
// Shared state encodings and AXI size helper for the CPU-to-AXI bridge.
package cpu_axi_bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AWW, W_B} wr_state_t;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cpu_axi_bridge_wbuf_fifo.sv
// Posted-write buffer; entry layout is {addr[31:0], ...} so the word address
// of every entry can be exported for the read-after-write hazard check.
module wbuf_fifo
    import cpu_axi_bridge_pkg::*;
#(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               empty,
    output logic [CW-1:0]      count,
    output logic [DEPTH-1:0]   vld,
    output logic [30*DEPTH-1:0] tags
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push_ok) begin
                wptr      <= wptr + PW'(1);
                vld[wptr] <= 1'b1;
            end
            if (pop_ok) begin
                rptr      <= rptr + PW'(1);
                vld[rptr] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= din;
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_tag
        assign tags[30*j +: 30] = mem[j][WIDTH-1 -: 30];
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Arbitrates NCH sram-like channels onto a single-beat AXI3 bus with a
// posted write buffer and a RAW stall for reads hitting buffered writes.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter int NCH = 2,
    parameter int WB_DEPTH = 4,
    parameter int DATA_W = 32,
    localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_wr,
    input  logic [2*NCH-1:0]      ch_size,
    input  logic [32*NCH-1:0]     ch_addr,
    input  logic [DATA_W*NCH-1:0] ch_wdata,
    input  logic [STRB_W*NCH-1:0] ch_wstrb,
    output logic [NCH-1:0]        ch_addr_ok,
    output logic [NCH-1:0]        ch_data_ok,
    output logic [DATA_W-1:0]     ch_rdata,
    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [31:0]           awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int EW = 34 + STRB_W + DATA_W;
    localparam int CW = $clog2(WB_DEPTH) + 1;

    rd_state_t rs, rs_n;
    wr_state_t ws, ws_n;

    logic [EW-1:0]         wb_dout;
    logic                  wb_empty;
    logic [CW-1:0]         wb_count;
    logic [WB_DEPTH-1:0]   wb_vld;
    logic [30*WB_DEPTH-1:0] wb_tags;
    logic                  wb_pop;
    logic                  wb_load;

    logic [NCH-1:0]        hit;
    logic                  gnt;
    logic                  gnt_wr;
    logic [ID_W-1:0]       gnt_id;
    logic [31:0]           sel_addr;
    logic [1:0]            sel_size;
    logic [DATA_W-1:0]     sel_wdata;
    logic [STRB_W-1:0]     sel_wstrb;
    logic                  elig;
    logic [NCH-1:0]        wr_ok;
    logic [NCH-1:0]        rd_ok;
    logic                  aw_done;
    logic                  w_done;

    wbuf_fifo #(.WIDTH(EW), .DEPTH(WB_DEPTH)) u_wbuf (
        .clk    (clk),
        .resetn (resetn),
        .push   (gnt && gnt_wr),
        .pop    (wb_pop),
        .din    ({sel_addr, sel_size, sel_wstrb, sel_wdata}),
        .dout   (wb_dout),
        .empty  (wb_empty),
        .count  (wb_count),
        .vld    (wb_vld),
        .tags   (wb_tags)
    );

    // The in-flight head stays valid until its B response, so it is covered.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NCH; i++)
            for (int j = 0; j < WB_DEPTH; j++)
                if (wb_vld[j] && wb_tags[30*j +: 30] == ch_addr[32*i+2 +: 30])
                    hit[i] = 1'b1;
    end

    // Later iterations override earlier ones: highest index wins.
    always_comb begin
        gnt       = 1'b0;
        gnt_wr    = 1'b0;
        gnt_id    = '0;
        sel_addr  = '0;
        sel_size  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        elig      = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            elig = ch_wr[i] ? (wb_count < CW'(WB_DEPTH))
                            : (rs == R_IDLE && !hit[i]);
            if (resetn && ch_req[i] && elig) begin
                gnt       = 1'b1;
                gnt_wr    = ch_wr[i];
                gnt_id    = ID_W'(i);
                sel_addr  = ch_addr[32*i +: 32];
                sel_size  = ch_size[2*i +: 2];
                sel_wdata = ch_wdata[DATA_W*i +: DATA_W];
                sel_wstrb = ch_wstrb[STRB_W*i +: STRB_W];
            end
        end
        for (int i = 0; i < NCH; i++)
            ch_addr_ok[i] = gnt && gnt_id == ID_W'(i);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rs <= R_IDLE;
            ws <= W_IDLE;
        end else begin
            rs <= rs_n;
            ws <= ws_n;
        end
    end

    always_comb begin
        rs_n    = rs;
        arvalid = 1'b0;
        rready  = 1'b0;
        case (rs)
            R_IDLE: if (gnt && !gnt_wr) rs_n = R_AR;
            R_AR: begin
                arvalid = 1'b1;
                if (arready) rs_n = R_R;
            end
            R_R: begin
                rready = 1'b1;
                if (rvalid) rs_n = R_IDLE;
            end
            default: rs_n = R_IDLE;
        endcase
    end

    always_comb begin
        ws_n    = ws;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        wb_pop  = 1'b0;
        wb_load = 1'b0;
        case (ws)
            W_IDLE: if (!wb_empty) begin
                ws_n    = W_AWW;
                wb_load = 1'b1;
            end
            W_AWW: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || awready) && (w_done || wready))
                    ws_n = W_B;
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wb_pop = 1'b1;
                    ws_n   = W_IDLE;
                end
            end
            default: ws_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arid     <= '0;
            araddr   <= '0;
            arsize   <= '0;
            ch_rdata <= '0;
            rd_ok    <= '0;
            wr_ok    <= '0;
        end else begin
            if (rs == R_IDLE && gnt && !gnt_wr) begin
                arid   <= gnt_id;
                araddr <= sel_addr;
                arsize <= axi_size(sel_size);
            end
            rd_ok <= '0;
            if (rs == R_R && rvalid) begin
                ch_rdata <= rdata;
                for (int i = 0; i < NCH; i++)
                    rd_ok[i] <= rid == ID_W'(i);
            end
            for (int i = 0; i < NCH; i++)
                wr_ok[i] <= ch_addr_ok[i] && gnt_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (wb_load) begin
                awaddr <= wb_dout[EW-1 -: 32];
                awsize <= axi_size(wb_dout[EW-33 -: 2]);
                wstrb  <= wb_dout[DATA_W +: STRB_W];
                wdata  <= wb_dout[DATA_W-1:0];
            end
            if (ws == W_AWW) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    assign ch_data_ok = wr_ok | rd_ok;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: AXI slave model, per-channel
// scoreboard queues and immediate-assertion checks.
module tb_cpu_axi_bridge;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int SW  = 4;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    ch_req = '0;
    logic [NCH-1:0]    ch_wr = '0;
    logic [2*NCH-1:0]  ch_size = '0;
    logic [32*NCH-1:0] ch_addr = '0;
    logic [DW*NCH-1:0] ch_wdata = '0;
    logic [SW*NCH-1:0] ch_wstrb = '0;
    logic [NCH-1:0]    ch_addr_ok, ch_data_ok;
    logic [DW-1:0]     ch_rdata;
    logic [0:0]  arid, rid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic [3:0]  wstrb;
    logic arvalid, arready, rvalid, rready;
    logic awvalid, awready, wvalid, wready, bvalid, bready;

    cpu_axi_bridge #(.NCH(NCH), .WB_DEPTH(4), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
        .ch_rdata(ch_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int b_cnt = 0;
    int b_first = -1;
    int last_ok [NCH];
    exp_t q0 [$];
    exp_t q1 [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // AXI slave model
    bit ar_en = 1, r_en = 1, aw_en = 1, w_en = 1, b_en = 1;
    logic [31:0] smem [int];
    logic        r_pend, aw_got, w_got;
    logic [0:0]  r_id_q;
    logic [31:0] r_dat_q, aw_a_q, w_d_q;
    logic [3:0]  w_s_q;

    assign arready = ar_en;
    assign rvalid  = r_pend && r_en;
    assign rid     = r_id_q;
    assign rdata   = r_dat_q;
    assign awready = aw_en;
    assign wready  = w_en;
    assign bvalid  = aw_got && w_got && b_en;

    function automatic int key(input logic [31:0] a);
        return int'(a[31:2]);
    endfunction

    function automatic logic [31:0] sread(input logic [31:0] a);
        if (smem.exists(key(a))) return smem[key(a)];
        return ~a;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            r_pend <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            r_id_q <= '0;
        end else begin
            if (rvalid && rready) r_pend <= 1'b0;
            if (arvalid && arready) begin
                r_pend  <= 1'b1;
                r_id_q  <= arid;
                r_dat_q <= sread(araddr);
            end
            if (awvalid && awready) begin
                aw_got <= 1'b1;
                aw_a_q <= awaddr;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1;
                w_d_q <= wdata;
                w_s_q <= wstrb;
            end
            if (bvalid && bready) begin
                logic [31:0] m;
                m = sread(aw_a_q);
                for (int b = 0; b < 4; b++)
                    if (w_s_q[b]) m[8*b +: 8] = w_d_q[8*b +: 8];
                smem[key(aw_a_q)] = m;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_cnt++;
                if (b_first < 0) b_first = cyc;
            end
        end
        cyc++;
    end

    // Scoreboard side: pop on every data_ok pulse
    always @(negedge clk) begin
        exp_t e;
        bit got;
        if (resetn) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_data_ok[c]) begin
                    got = 0;
                    if (c == 0 && q0.size() > 0) begin
                        e = q0.pop_front(); got = 1;
                    end
                    if (c == 1 && q1.size() > 0) begin
                        e = q1.pop_front(); got = 1;
                    end
                    chk($sformatf("ch%0d_expected_ok", c), {31'b0, got}, 1);
                    if (got) begin
                        last_ok[c] = cyc;
                        if (e.wr) chk("wr_ok_latency", cyc, e.cyc);
                        else      chk("rdata", ch_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic set_req(input int c, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz,
                           input logic [3:0] st);
        ch_req[c] = 1'b1;
        ch_wr[c] = wr;
        ch_addr[32*c +: 32] = a;
        ch_wdata[32*c +: 32] = d;
        ch_size[2*c +: 2] = sz;
        ch_wstrb[4*c +: 4] = st;
    endtask

    // Call at a negedge; returns at the negedge after acceptance.
    task automatic issue(input int c, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] exp,
                         output int acc);
        exp_t e;
        acc = -1;
        set_req(c, wr, a, d, sz, st);
        for (int k = 0; k < 30; k++) begin
            #1;
            if (ch_addr_ok[c]) begin
                acc = cyc;
                e.wr = wr;
                e.data = exp;
                e.cyc = cyc + 1;
                if (c == 0) q0.push_back(e);
                else        q1.push_back(e);
                @(negedge clk);
                ch_req[c] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        ch_req[c] = 1'b0;
        chk("accept_timeout", 0, 1);
    endtask

    task automatic hold_low(input int c, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            #1;
            chk(tag, ch_addr_ok[c], 0);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        for (int k = 0; k < budget && quiet < 3; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !arvalid && !rready &&
                !awvalid && !wvalid && !bready)
                quiet++;
            else
                quiet = 0;
        end
        chk("idle_timeout", quiet >= 3, 1);
    endtask

    initial begin
        int a0, a1, bc;
        bit seen;
        smem[key(32'h1FC0_0000)] = 32'hDEAD_BEEF;
        smem[key(32'h0000_0100)] = 32'h1111_2222;
        smem[key(32'h0000_0400)] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("rst_data_ok", ch_data_ok, 0);
        chk("rst_rdata", ch_rdata, 0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: basic read, minimum latency
        issue(0, 0, 32'h1FC0_0000, 0, 2'd2, 4'h0, 32'hDEAD_BEEF, a0);
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1FC0_0000);
        chk("t1_arsize", arsize, 3'd2);
        chk("t1_arid", arid, 0);
        wait_idle(20);
        chk("t1_latency", last_ok[0] - a0, 3);

        // 2: simultaneous read/write, higher channel first
        fork
            issue(0, 0, 32'h0000_0100, 0, 2'd2, 4'h0, 32'h1111_2222, a0);
            issue(1, 1, 32'h0000_0200, 32'h3333_4444, 2'd2, 4'hF, 0, a1);
        join
        chk("t2_order", a0, a1 + 1);
        wait_idle(30);
        issue(0, 0, 32'h0000_0200, 0, 2'd2, 4'h0, 32'h3333_4444, a0);
        wait_idle(20);

        // 3: buffer full blocks the fifth write until a pop
        aw_en = 0;
        for (int i = 0; i < 4; i++)
            issue(1, 1, 32'h300 + 32'(4*i), 32'hA000_0000 | 32'(i),
                  2'd2, 4'hF, 0, a1);
        set_req(1, 1, 32'h310, 32'hA000_0004, 2'd2, 4'hF);
        hold_low(1, 4, "t3_full_hold");
        b_first = -1;
        aw_en = 1;
        issue(1, 1, 32'h310, 32'hA000_0004, 2'd2, 4'hF, 0, a1);
        chk("t3_accept_after_pop", a1, b_first + 1);
        wait_idle(60);
        issue(0, 0, 32'h0000_0304, 0, 2'd2, 4'h0, 32'hA000_0001, a0);
        wait_idle(20);

        // 4: RAW hazard on a pending write
        b_en = 0;
        issue(1, 1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 4'hF, 0, a1);
        repeat (4) @(negedge clk);
        set_req(0, 0, 32'h8000_0012, 0, 2'd1, 4'h0);
        hold_low(0, 4, "t4_raw_hold");
        b_first = -1;
        b_en = 1;
        issue(0, 0, 32'h8000_0012, 0, 2'd1, 4'h0, 32'hCAFE_F00D, a0);
        chk("t4_accept_after_b", a0, b_first + 1);
        wait_idle(20);

        // 5: W channel accepted well before AW
        aw_en = 0;
        bc = b_cnt;
        issue(1, 1, 32'h0000_0400, 32'hAABB_CCDD, 2'd2, 4'h3, 0, a1);
        @(negedge clk);
        chk("t5_awvalid0", awvalid, 1);
        chk("t5_wvalid0", wvalid, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_awvalid_hold", awvalid, 1);
            chk("t5_wvalid_drop", wvalid, 0);
            chk("t5_bready_wait", bready, 0);
        end
        aw_en = 1;
        @(negedge clk);
        chk("t5_bready", bready, 1);
        wait_idle(20);
        chk("t5_single_b", b_cnt - bc, 1);
        issue(0, 0, 32'h0000_0400, 0, 2'd2, 4'h0, 32'h1122_CCDD, a0);
        wait_idle(20);

        // 6: reset while waiting for R
        aw_en = 0;
        r_en = 0;
        issue(1, 1, 32'h0000_0700, 32'h7777_7777, 2'd2, 4'hF, 0, a1);
        issue(0, 0, 32'h0000_0600, 0, 2'd2, 4'h0, 32'hFFFF_F9FF, a0);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (rready) seen = 1;
            else @(negedge clk);
        end
        chk("t6_in_r_r", seen, 1);
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("t6_arvalid", arvalid, 0);
        chk("t6_rready", rready, 0);
        chk("t6_awvalid", awvalid, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_bready", bready, 0);
        chk("t6_data_ok", ch_data_ok, 0);
        chk("t6_addr_ok", ch_addr_ok, 0);
        bc = b_cnt;
        r_en = 1;
        aw_en = 1;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_fifo_empty", awvalid, 0);
        chk("t6_no_b", b_cnt - bc, 0);
        issue(0, 0, 32'h1FC0_0000, 0, 2'd2, 4'h0, 32'hDEAD_BEEF, a0);
        wait_idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
